// File: rtl/pcm_frame_packer_pkg.sv
// pcm_frame_packer_pkg
//   Shared definitions for the PCM frame packer and its byte serializer:
//   the control-state enum, the default header size and a helper that
//   converts a sample width in bits into a byte count.
package pcm_frame_packer_pkg;

  // Control states of the packer. SEQ_LO/SEQ_HI are only entered when the
  // sequence-number header feature is built in.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    CHECK   = 3'd2,
    SEQ_LO  = 3'd3,
    SEQ_HI  = 3'd4,
    HANDOFF = 3'd5
  } state_e;

  // Size of the fixed header that precedes the payload in every bank.
  localparam int HDR_BYTES_DEFAULT = 14;

  // Bytes occupied by one sample of the given bit width.
  function automatic int bytes_per_sample(input int sample_w);
    return sample_w / 8;
  endfunction

endpackage

// File: rtl/pcm_frame_packer_serializer.sv
// pcm_byte_serializer
//   Holds a snapshot of one PCM strobe (all channels) and walks through it
//   one byte at a time, channel 0 first, each sample least-significant byte
//   first.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     load_i      : capture pcm_data_i and point at channel 0, byte 0
//     adv_i       : step to the next byte (ignored while load_i is high)
//     pcm_data_i  : channel c at bits [c*SAMPLE_W +: SAMPLE_W]
//     byte_o      : snapshot byte currently selected
//     off_o       : payload offset of that byte within the strobe (ch*B+byte)
//     last_o      : selected byte is the last byte of the last channel
module pcm_byte_serializer
  import pcm_frame_packer_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int SAMPLE_W = 16,
  localparam int B       = bytes_per_sample(SAMPLE_W),
  localparam int OFF_W   = $clog2(N_CH * B + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_i,
  input  logic                       adv_i,
  input  logic [N_CH*SAMPLE_W-1:0]   pcm_data_i,
  output logic [7:0]                 byte_o,
  output logic [OFF_W-1:0]           off_o,
  output logic                       last_o
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BY_W = (B > 1) ? $clog2(B) : 1;

  logic [N_CH*SAMPLE_W-1:0] snap_q, snap_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [BY_W-1:0]          byte_q, byte_d;
  logic [N_CH*SAMPLE_W-1:0] shifted_s;
  int                       bit_pos_s;

  // Byte selection: the flat byte index ch*B+byte maps straight onto the
  // packed snapshot because channels are packed contiguously, LSB first.
  always_comb begin
    bit_pos_s = (int'(ch_q) * B + int'(byte_q)) * 8;
    shifted_s = snap_q >> bit_pos_s;
    byte_o    = shifted_s[7:0];
    off_o     = OFF_W'(int'(ch_q) * B + int'(byte_q));
    last_o    = (ch_q == CH_W'(N_CH - 1)) && (byte_q == BY_W'(B - 1));
  end

  // Next snapshot and byte/channel counters.
  always_comb begin
    snap_d = snap_q;
    ch_d   = ch_q;
    byte_d = byte_q;
    if (load_i) begin
      snap_d = pcm_data_i;
      ch_d   = {CH_W{1'b0}};
      byte_d = {BY_W{1'b0}};
    end else if (adv_i) begin
      if (byte_q == BY_W'(B - 1)) begin
        byte_d = {BY_W{1'b0}};
        if (ch_q == CH_W'(N_CH - 1)) begin
          ch_d = {CH_W{1'b0}};
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end else begin
        byte_d = byte_q + BY_W'(1);
      end
    end else begin
      snap_d = snap_q;
    end
  end

  // Snapshot and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= {(N_CH*SAMPLE_W){1'b0}};
      ch_q   <= {CH_W{1'b0}};
      byte_q <= {BY_W{1'b0}};
    end else begin
      snap_q <= snap_d;
      ch_q   <= ch_d;
      byte_q <= byte_d;
    end
  end

endmodule

// File: rtl/pcm_frame_packer.sv
// pcm_frame_packer
//   Captures N_CH signed PCM samples per strobe and writes them little-endian
//   into the payload area of a ping-pong BRAM (two banks, fixed header at the
//   start of each). When SAMPLES_PER_FRAME strobes have been written the bank
//   is handed to the Ethernet transmitter and capture moves to the other bank.
//   If the transmitter is still busy at handoff the frame is dropped and the
//   same bank is refilled.
//   Build option: define SEQ_HEADER_EN to write the frame sequence number
//   (little-endian) into the last two header bytes before each handoff.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     pcm_stb      : one-cycle strobe, pcm_data valid
//     pcm_data     : channel c at bits [c*SAMPLE_W +: SAMPLE_W]
//     eth_busy     : transmitter busy (looked at only during handoff)
//     bram_wr_en   : BRAM byte write enable
//     bram_wr_addr : {bank, offset}
//     bram_wr_data : byte to write
//     eth_start    : one-cycle pulse, start sending eth_bank
//     eth_bank     : bank to transmit, held until the next pulse
//     overrun      : sticky error (strobe while busy, or frame dropped)
//     frame_seq    : frames handed to the transmitter, wraps at 16 bits
//   All outputs are registered; each reflects the state of the previous cycle.
module pcm_frame_packer
  import pcm_frame_packer_pkg::*;
#(
  parameter int N_CH              = 4,
  parameter int SAMPLE_W          = 16,
  parameter int SAMPLES_PER_FRAME = 16,
  parameter int HDR_BYTES         = HDR_BYTES_DEFAULT,
  parameter int BANK_AW           = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pcm_stb,
  input  logic [N_CH*SAMPLE_W-1:0] pcm_data,
  input  logic                     eth_busy,
  output logic                     bram_wr_en,
  output logic [BANK_AW:0]         bram_wr_addr,
  output logic [7:0]               bram_wr_data,
  output logic                     eth_start,
  output logic                     eth_bank,
  output logic                     overrun,
  output logic [15:0]              frame_seq
);

  localparam int B           = bytes_per_sample(SAMPLE_W);
  localparam int FRAME_BYTES = N_CH * B * SAMPLES_PER_FRAME;
  localparam int OFF_W       = $clog2(N_CH * B + 1);
  localparam int CNT_W       = $clog2(SAMPLES_PER_FRAME + 1);

`ifdef SEQ_HEADER_EN
  localparam state_e FULL_NEXT = SEQ_LO;
`else
  localparam state_e FULL_NEXT = HANDOFF;
`endif

  // Parameter sanity checks at elaboration.
  if (HDR_BYTES + FRAME_BYTES > (1 << BANK_AW)) begin : g_size_err
    $error("pcm_frame_packer: header plus payload does not fit in a bank");
  end
  if ((SAMPLE_W % 8 != 0) || (SAMPLE_W < 8) || (SAMPLE_W > 32)) begin : g_width_err
    $error("pcm_frame_packer: SAMPLE_W must be a multiple of 8 in 8..32");
  end
  if ((N_CH < 1) || (N_CH > 16)) begin : g_ch_err
    $error("pcm_frame_packer: N_CH must be in 1..16");
  end
`ifdef SEQ_HEADER_EN
  if (HDR_BYTES < 2) begin : g_hdr_err
    $error("pcm_frame_packer: sequence header needs at least two header bytes");
  end
`endif

  state_e             state_q, state_d;
  logic               wr_bank_q, wr_bank_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [15:0]        frame_seq_q, frame_seq_d;
  logic               overrun_q, overrun_d;
  logic               eth_bank_q, eth_bank_d;
  logic               eth_start_q, eth_start_d;
  logic               wr_en_q, wr_en_d;
  logic [BANK_AW:0]   wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;

  logic               ser_load_s;
  logic               ser_adv_s;
  logic [7:0]         ser_byte_s;
  logic [OFF_W-1:0]   ser_off_s;
  logic               ser_last_s;
  logic [BANK_AW-1:0] pay_off_s;

  pcm_byte_serializer #(
    .N_CH     (N_CH),
    .SAMPLE_W (SAMPLE_W)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ser_load_s),
    .adv_i      (ser_adv_s),
    .pcm_data_i (pcm_data),
    .byte_o     (ser_byte_s),
    .off_o      (ser_off_s),
    .last_o     (ser_last_s)
  );

  // Bank-relative address of the byte the serializer is presenting.
  always_comb begin
    pay_off_s = BANK_AW'(HDR_BYTES)
              + BANK_AW'(sample_cnt_q) * BANK_AW'(N_CH * B)
              + BANK_AW'(ser_off_s);
  end

  // Next-state and next-output logic of the packer FSM.
  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    sample_cnt_d = sample_cnt_q;
    frame_seq_d  = frame_seq_q;
    eth_bank_d   = eth_bank_q;
    eth_start_d  = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = {(BANK_AW+1){1'b0}};
    wr_data_d    = 8'h00;
    ser_load_s   = 1'b0;
    ser_adv_s    = 1'b0;

    // A strobe that arrives while a sample is still being processed is lost.
    if (pcm_stb && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        if (pcm_stb) begin
          ser_load_s = 1'b1;
          state_d    = WRITE;
        end else begin
          state_d    = IDLE;
        end
      end

      WRITE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {wr_bank_q, pay_off_s};
        wr_data_d = ser_byte_s;
        if (ser_last_s) begin
          state_d   = CHECK;
        end else begin
          ser_adv_s = 1'b1;
        end
      end

      CHECK: begin
        sample_cnt_d = sample_cnt_q + CNT_W'(1);
        if (sample_cnt_q == CNT_W'(SAMPLES_PER_FRAME - 1)) begin
          state_d = FULL_NEXT;
        end else begin
          state_d = IDLE;
        end
      end

`ifdef SEQ_HEADER_EN
      // Header gets the index of the frame being handed off (pre-increment),
      // written even if the handoff then drops the frame.
      SEQ_LO: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {wr_bank_q, BANK_AW'(HDR_BYTES - 2)};
        wr_data_d = frame_seq_q[7:0];
        state_d   = SEQ_HI;
      end

      SEQ_HI: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {wr_bank_q, BANK_AW'(HDR_BYTES - 1)};
        wr_data_d = frame_seq_q[15:8];
        state_d   = HANDOFF;
      end
`else
      SEQ_LO: begin
        state_d = IDLE;
      end

      SEQ_HI: begin
        state_d = IDLE;
      end
`endif

      HANDOFF: begin
        sample_cnt_d = {CNT_W{1'b0}};
        state_d      = IDLE;
        if (!eth_busy) begin
          eth_start_d = 1'b1;
          eth_bank_d  = wr_bank_q;
          wr_bank_d   = ~wr_bank_q;
          frame_seq_d = frame_seq_q + 16'd1;
        end else begin
          // Transmitter still owns the other bank: drop this frame and
          // refill the same bank.
          overrun_d   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_bank_q    <= 1'b0;
      sample_cnt_q <= {CNT_W{1'b0}};
      frame_seq_q  <= 16'd0;
      overrun_q    <= 1'b0;
      eth_bank_q   <= 1'b0;
      eth_start_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= {(BANK_AW+1){1'b0}};
      wr_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      sample_cnt_q <= sample_cnt_d;
      frame_seq_q  <= frame_seq_d;
      overrun_q    <= overrun_d;
      eth_bank_q   <= eth_bank_d;
      eth_start_q  <= eth_start_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bram_wr_en   = wr_en_q;
  assign bram_wr_addr = wr_addr_q;
  assign bram_wr_data = wr_data_q;
  assign eth_start    = eth_start_q;
  assign eth_bank     = eth_bank_q;
  assign overrun      = overrun_q;
  assign frame_seq    = frame_seq_q;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Bench for pcm_frame_packer with N_CH=2, SAMPLE_W=16, SAMPLES_PER_FRAME=4,
// HDR_BYTES=14, BANK_AW=10. Expected BRAM writes and handoffs are queued
// when strobes are driven and compared as the DUT produces them.
module tb_pcm_frame_packer;

  localparam int N_CH     = 2;
  localparam int SAMPLE_W = 16;
  localparam int SPF      = 4;
  localparam int HDR      = 14;
  localparam int BANK_AW  = 10;
  localparam int NB       = N_CH * SAMPLE_W / 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     pcm_stb;
  logic [N_CH*SAMPLE_W-1:0] pcm_data;
  logic                     eth_busy;
  logic                     bram_wr_en;
  logic [BANK_AW:0]         bram_wr_addr;
  logic [7:0]               bram_wr_data;
  logic                     eth_start;
  logic                     eth_bank;
  logic                     overrun;
  logic [15:0]              frame_seq;

  always #5 clk = ~clk;

  pcm_frame_packer #(
    .N_CH              (N_CH),
    .SAMPLE_W          (SAMPLE_W),
    .SAMPLES_PER_FRAME (SPF),
    .HDR_BYTES         (HDR),
    .BANK_AW           (BANK_AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pcm_stb      (pcm_stb),
    .pcm_data     (pcm_data),
    .eth_busy     (eth_busy),
    .bram_wr_en   (bram_wr_en),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .eth_start    (eth_start),
    .eth_bank     (eth_bank),
    .overrun      (overrun),
    .frame_seq    (frame_seq)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int eth_start_cnt = 0;

  // Scoreboard queues and a log of observed writes ({addr, data}).
  logic [BANK_AW:0] exp_addr_q[$];
  logic [7:0]       exp_data_q[$];
  logic             exp_bank_q[$];
  logic [15:0]      exp_seq_q[$];
  logic [18:0]      wr_log[$];

  // Reference model state.
  logic        m_bank;
  int          m_cnt;
  logic [15:0] m_seq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    else return 19'h7FFFF;
  endfunction

  task automatic model_reset();
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_bank_q.delete();
    exp_seq_q.delete();
    m_bank = 1'b0;
    m_cnt  = 0;
    m_seq  = 16'd0;
  endtask

  task automatic model_strobe(input logic [31:0] d);
    for (int i = 0; i < NB; i++) begin
      exp_addr_q.push_back({m_bank, 10'(HDR + m_cnt * NB + i)});
      exp_data_q.push_back(d[i*8 +: 8]);
    end
    m_cnt++;
    if (m_cnt == SPF) begin
      m_cnt = 0;
      if (!eth_busy) begin
        exp_bank_q.push_back(m_bank);
        exp_seq_q.push_back(m_seq + 16'd1);
        m_bank = ~m_bank;
        m_seq  = m_seq + 16'd1;
      end
    end
  endtask

  task automatic strobe(input logic [31:0] d, input bit accept);
    @(negedge clk);
    pcm_stb  = 1'b1;
    pcm_data = d;
    if (accept) model_strobe(d);
    @(negedge clk);
    pcm_stb  = 1'b0;
  endtask

  // Strobe that closes a frame; measures cycles until eth_start.
  task automatic strobe_handoff(input logic [31:0] d, input int exp_lat);
    int lat;
    lat = -1;
    strobe(d, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (eth_start && (lat < 0)) lat = k;
    end
    check("eth_start_latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_wr_en",   32'(bram_wr_en),   32'd0);
    check("rst_async_wr_addr", 32'(bram_wr_addr), 32'd0);
    check("rst_async_wr_data", 32'(bram_wr_data), 32'd0);
    check("rst_async_overrun", 32'(overrun),      32'd0);
    model_reset();
    gap(2);
    rst_n = 1'b1;
    gap(1);
  endtask

  // Output monitor: compares writes and handoffs against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_wr_en) begin
        wr_log.push_back({bram_wr_addr, bram_wr_data});
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write", 32'(bram_wr_addr), 32'hFFFF_FFFF);
        end else begin
          check("wr_addr", 32'(bram_wr_addr), 32'(exp_addr_q.pop_front()));
          check("wr_data", 32'(bram_wr_data), 32'(exp_data_q.pop_front()));
        end
      end
      if (eth_start) begin
        eth_start_cnt++;
        if (exp_bank_q.size() == 0) begin
          check("unexpected_eth_start", 32'd1, 32'd0);
        end else begin
          check("eth_bank", 32'(eth_bank), 32'(exp_bank_q.pop_front()));
          check("frame_seq_at_start", 32'(frame_seq), 32'(exp_seq_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int base_cnt;
    rst_n    = 1'b0;
    pcm_stb  = 1'b0;
    pcm_data = '0;
    eth_busy = 1'b0;
    model_reset();
    gap(3);
    check("reset_wr_en",     32'(bram_wr_en),   32'd0);
    check("reset_wr_addr",   32'(bram_wr_addr), 32'd0);
    check("reset_wr_data",   32'(bram_wr_data), 32'd0);
    check("reset_eth_start", 32'(eth_start),    32'd0);
    check("reset_eth_bank",  32'(eth_bank),     32'd0);
    check("reset_overrun",   32'(overrun),      32'd0);
    check("reset_frame_seq", 32'(frame_seq),    32'd0);
    rst_n = 1'b1;
    gap(2);

    // Single strobe: four bytes LSB first at offsets 14..17.
    wr_log.delete();
    strobe(32'hBEEF_1234, 1'b1);
    gap(8);
    check("t1_log0", 32'(log_at(0)), 32'({11'd14, 8'h34}));
    check("t1_log1", 32'(log_at(1)), 32'({11'd15, 8'h12}));
    check("t1_log2", 32'(log_at(2)), 32'({11'd16, 8'hEF}));
    check("t1_log3", 32'(log_at(3)), 32'({11'd17, 8'hBE}));
    check("t1_wr_en_low", 32'(bram_wr_en), 32'd0);
    check("t1_drained", 32'(exp_addr_q.size()), 32'd0);

    // Complete frame 0, then first sample of frame 1 lands in bank 1.
    strobe(32'h0102_0304, 1'b1); gap(9);
    strobe(32'hA5A5_5A5A, 1'b1); gap(9);
    wr_log.delete();
    strobe_handoff(32'hDEAD_C0DE, 6);
    check("t2_last_addr", 32'(log_at(3) >> 8), 32'd29);
    check("t2_frame_seq", 32'(frame_seq), 32'd1);
    check("t2_eth_bank",  32'(eth_bank),  32'd0);
    wr_log.delete();
    strobe(32'h1111_2222, 1'b1); gap(9);
    check("t2_bank1_addr", 32'(log_at(0) >> 8), 32'h40E);

    // Finish frame 1 in bank 1; the next strobe returns to bank 0.
    strobe(32'h3333_4444, 1'b1); gap(9);
    strobe(32'h5555_6666, 1'b1); gap(9);
    strobe_handoff(32'h7777_8888, 6);
    check("t3_frame_seq", 32'(frame_seq), 32'd2);
    check("t3_eth_bank",  32'(eth_bank),  32'd1);
    wr_log.delete();
    strobe(32'h9999_AAAA, 1'b1); gap(9);
    check("t3_bank0_addr", 32'(log_at(0) >> 8), 32'd14);

    // Reset in the middle of a sample write.
    strobe(32'hCAFE_F00D, 1'b1);
    @(posedge clk);
    mid_reset();
    check("t4_frame_seq", 32'(frame_seq), 32'd0);
    wr_log.delete();
    strobe(32'h0BAD_BEEF, 1'b1); gap(9);
    check("t4_restart_addr", 32'(log_at(0) >> 8), 32'd14);

    // Strobe two cycles after an accepted one is ignored and flags overrun.
    check("t5_overrun_before", 32'(overrun), 32'd0);
    wr_log.delete();
    @(negedge clk);
    pcm_stb = 1'b1; pcm_data = 32'h1357_2468; model_strobe(32'h1357_2468);
    @(negedge clk);
    pcm_stb = 1'b0;
    @(negedge clk);
    pcm_stb = 1'b1; pcm_data = 32'hFFFF_FFFF;
    @(negedge clk);
    pcm_stb = 1'b0;
    gap(10);
    check("t5_overrun", 32'(overrun), 32'd1);
    check("t5_write_count", 32'(wr_log.size()), 32'(NB));
    check("t5_drained", 32'(exp_addr_q.size()), 32'd0);

    // Transmitter busy for frame 0: frame dropped, bank 0 refilled.
    mid_reset();
    eth_busy = 1'b1;
    base_cnt = eth_start_cnt;
    strobe(32'h0000_0001, 1'b1); gap(9);
    strobe(32'h0000_0002, 1'b1); gap(9);
    strobe(32'h0000_0003, 1'b1); gap(9);
    strobe(32'h0000_0004, 1'b1); gap(12);
    check("t6_no_eth_start", 32'(eth_start_cnt - base_cnt), 32'd0);
    check("t6_overrun",   32'(overrun),   32'd1);
    check("t6_frame_seq", 32'(frame_seq), 32'd0);
    eth_busy = 1'b0;
    wr_log.delete();
    strobe(32'h0000_0005, 1'b1); gap(9);
    check("t6_rewrite_addr", 32'(log_at(0) >> 8), 32'd14);

    check("final_wr_drained",  32'(exp_addr_q.size()), 32'd0);
    check("final_eth_drained", 32'(exp_bank_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
